// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding, constants and helpers for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_FULL  = 2'd3
  } state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory req/ack + rvalid bus
//   IM_req/IM_addr   fetch -> memory, transfer on IM_req && IM_ack
//   IM_ack           memory accepts the request
//   IM_rvalid/IM_rdata one-cycle response for the accepted request
interface fetch_if;
  logic        IM_req;
  logic [31:0] IM_addr;
  logic        IM_ack;
  logic        IM_rvalid;
  logic [31:0] IM_rdata;
  modport master (output IM_req, IM_addr, input IM_ack, IM_rvalid, IM_rdata);
  modport slave  (input IM_req, IM_addr, output IM_ack, IM_rvalid, IM_rdata);
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr, pc, full} holding register for a response that lands while decode stalls
//   SYS_clk/SYS_reset  falling-edge clock, async active-high reset
//   i_write            capture i_instr/i_pc and mark full
//   i_read/i_clear     empty the entry (take priority over i_write)
//   o_instr/o_pc/o_full stored entry
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        i_write,
  input  logic        i_read,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_full
);
  logic [31:0] r_instr, r_pc;
  logic        r_full;
  always_ff @(negedge SYS_clk or posedge SYS_reset)
    if (SYS_reset) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_full  <= 1'b0;
    end else if (i_clear || i_read) begin
      r_full  <= 1'b0;
    end else if (i_write) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_full  <= 1'b1;
    end
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_full  = r_full;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage owning the PC, one outstanding IM request, skid buffer and redirect flush
//   SYS_clk/SYS_reset  falling-edge clock, async active-high reset
//   D_stall/D_redirect/D_target  decode backpressure and taken branch/jump
//   im (fetch_if.master)         instruction-memory bus
//   F_instruction/F_PC/F_valid   slot delivered to decode; F_state debug
//   perf_*  counters when FETCH_PERF_EN is defined, otherwise tied to 0
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        D_stall,
  input  logic        D_redirect,
  input  logic [31:0] D_target,
  fetch_if.master     im,
  output logic [31:0] F_instruction,
  output logic [31:0] F_PC,
  output logic        F_valid,
  output logic [1:0]  F_state,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
  output logic [31:0] perf_stall
);
  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n, r_f_instr, w_f_instr_n, r_f_pc, w_f_pc_n;
  logic        r_f_valid, w_f_valid_n;
  logic        w_free, w_resp, w_buf_write, w_buf_read;
  logic [31:0] w_buf_instr, w_buf_pc;
  logic        w_buf_full;
  assign w_free = !r_f_valid || !D_stall;
  assign w_resp = r_state == S_WAIT && im.IM_rvalid;
  fetch_skid_buffer u_skid (
    .SYS_clk  (SYS_clk),
    .SYS_reset(SYS_reset),
    .i_write  (w_buf_write),
    .i_read   (w_buf_read),
    .i_clear  (D_redirect),
    .i_instr  (im.IM_rdata),
    .i_pc     (r_pc),
    .o_instr  (w_buf_instr),
    .o_pc     (w_buf_pc),
    .o_full   (w_buf_full)
  );
  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_f_valid_n = r_f_valid;
    w_f_instr_n = r_f_instr;
    w_f_pc_n    = r_f_pc;
    w_buf_write = 1'b0;
    w_buf_read  = 1'b0;
    if (D_redirect) begin
      w_pc_n      = D_target & ~32'd3;
      w_f_valid_n = 1'b0;
      // drain only while an accepted request is still owed a response
      w_state_n   = ((r_state == S_WAIT || r_state == S_DRAIN) && !im.IM_rvalid) ||
                    (r_state == S_REQ && im.IM_ack) ? S_DRAIN : S_REQ;
    end else begin
      if (w_free) begin
        w_f_valid_n = w_buf_full || w_resp;
        w_f_instr_n = w_buf_full ? w_buf_instr : w_resp ? im.IM_rdata : r_f_instr;
        w_f_pc_n    = w_buf_full ? w_buf_pc : w_resp ? r_pc : r_f_pc;
        w_buf_read  = w_buf_full;
      end
      unique case (r_state)
        S_REQ:   w_state_n = im.IM_ack ? S_WAIT : S_REQ;
        S_WAIT:  if (im.IM_rvalid) begin
          w_pc_n      = r_pc + PC_STEP;
          w_buf_write = !w_free;
          w_state_n   = w_free ? S_REQ : S_FULL;
        end
        S_FULL:  w_state_n = w_free ? S_REQ : S_FULL;
        S_DRAIN: w_state_n = im.IM_rvalid ? S_REQ : S_DRAIN;
      endcase
    end
  end
  always_ff @(negedge SYS_clk or posedge SYS_reset)
    if (SYS_reset) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_f_valid <= 1'b0;
      r_f_instr <= NOP;
      r_f_pc    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_f_valid <= w_f_valid_n;
      r_f_instr <= w_f_instr_n;
      r_f_pc    <= w_f_pc_n;
    end
  assign im.IM_req     = r_state == S_REQ && !SYS_reset;
  assign im.IM_addr    = r_pc;
  assign F_instruction = r_f_instr;
  assign F_PC          = r_f_pc;
  assign F_valid       = r_f_valid;
  assign F_state       = r_state;
`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_flushed, r_perf_stall;
  logic        w_fetched, w_flush;
  assign w_fetched = !D_redirect && w_free && (w_buf_full || w_resp);
  assign w_flush   = D_redirect && (r_f_valid || w_buf_full || r_state == S_WAIT ||
                                    (r_state == S_REQ && im.IM_ack));
  always_ff @(negedge SYS_clk or posedge SYS_reset)
    if (SYS_reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_fetched) r_perf_fetched <= sat_inc(r_perf_fetched);
      if (w_flush) r_perf_flushed <= sat_inc(r_perf_flushed);
      if (r_f_valid && D_stall) r_perf_stall <= sat_inc(r_perf_stall);
    end
  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
  assign perf_stall   = r_perf_stall;
`else
  assign perf_fetched = '0;
  assign perf_flushed = '0;
  assign perf_stall   = '0;
`endif
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `decode_stage`. Owns the PC and issues one instruction-memory request at a time over a req/ack + rvalid handshake, so memory latency may vary. Delivers `{F_instruction, F_PC, F_valid}` to decode, holds on decode stall, and flushes on a branch/jump redirect resolved in decode. A one-entry skid buffer absorbs a response that lands while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- SYS_clk  in  1  system clock; all state updates on the falling edge
- SYS_reset  in  1  reset, asynchronous, active-high
- D_stall  in  1  decode cannot accept a new instruction this cycle
- D_redirect  in  1  taken branch or jump resolved in decode
- D_target  in  32  redirect PC; word-aligned, bits [1:0] ignored
- IM_req  out  1  fetch request; high only in S_REQ and low while SYS_reset is high
- IM_addr  out  32  fetch address, equal to PC
- IM_ack  in  1  memory accepts the request; transfer completes when IM_req && IM_ack
- IM_rvalid  in  1  one-cycle pulse carrying the response for the accepted request
- IM_rdata  in  32  instruction word, valid with IM_rvalid
- F_instruction  out  32  instruction to decode
- F_PC  out  32  PC of F_instruction
- F_valid  out  1  F_instruction/F_PC hold a live instruction
- F_state  out  2  FSM state, for debug
- perf_fetched  out  32  instructions delivered to F (FETCH_PERF_EN)
- perf_flushed  out  32  instructions discarded by redirect (FETCH_PERF_EN)
- perf_stall  out  32  cycles with F_valid && D_stall (FETCH_PERF_EN)

## Operation
- **FSM states:** S_REQ=0, S_WAIT=1, S_DRAIN=2, S_FULL=3.
- **S_REQ:**
  - Drive IM_req=1 and IM_addr=PC.
  - On IM_ack, go to S_WAIT.
  - IM_addr may change while there is no ack; memory samples only on req&&ack.
  - IM_rvalid is ignored in this state.
- **S_WAIT:** on IM_rvalid:
  - If the F slot is free (!F_valid || !D_stall), load F with {IM_rdata, PC}, set PC+=4, go to S_REQ.
  - Otherwise write the skid buffer with {IM_rdata, PC}, set PC+=4, go to S_FULL.
- **S_FULL:** IM_req=0. When !D_stall, move the buffer into F, clear the buffer, go to S_REQ.
- **S_DRAIN:** IM_req=0. On IM_rvalid, discard the response, go to S_REQ.
- **F slot advance:** when !F_valid || !D_stall, in priority order:
  - load from the skid buffer if it is full;
  - else load from the incoming response;
  - else clear F_valid.
- **F slot hold:** while F_valid && D_stall, F_* hold unchanged.
- **Redirect** (priority over D_stall and over everything else):
  - PC ← {D_target[31:2], 2'b00}; F_valid ← 0; buffer cleared.
  - From S_WAIT, go to S_DRAIN.
  - From S_REQ with IM_ack in the same cycle, go to S_DRAIN (the stale request was accepted).
  - Otherwise go to S_REQ.
  - A response arriving in the redirect cycle is discarded.
  - No delay slot.
- **PC arithmetic:** 32-bit, wraps from 32'hFFFF_FFFC to 0.
- **Invariant:** at most one request outstanding; the buffer never overflows.

## Timing
- **Reset values:**
  - PC=RESET_PC, state S_REQ, F_valid=0, F_instruction=0, F_PC=0;
  - buffer empty, all perf counters 0, IM_req=0 while in reset.
- **Latency:**
  - A response at edge M appears on F_* after edge M (1 cycle).
  - With zero-wait memory (ack same cycle, rvalid next cycle), throughput is 1 instruction per 2 cycles.
- **Redirect at edge N:** IM_addr=D_target in cycle N+1, unless in S_DRAIN.
- **Reset mid-transaction:** state returns to S_REQ. Memory is reset by the same SYS_reset; any rvalid in S_REQ is ignored.
- **Simultaneous events:**
  - D_redirect + D_stall: redirect wins.
  - D_redirect + IM_rvalid: response discarded; go to S_REQ, since the request has completed.

## Configuration
- **FETCH_PERF_EN defined:**
  - All three counters are implemented.
  - perf_flushed increments by 1 per redirect that discards a valid F, a full buffer, or an in-flight request. Increment at most 1 per cycle.
  - Counters saturate at 32'hFFFF_FFFF.
- **FETCH_PERF_EN undefined:** the perf_* ports remain present and are tied to 0; no counter logic.

## Structure
- **Shared package `fetch_pkg`:**
  - state encoding constants S_REQ/S_WAIT/S_DRAIN/S_FULL;
  - PC_STEP=32'd4;
  - NOP=32'h0000_0000.
- **Sub-module `fetch_skid_buffer`:**
  - one-entry {instr, pc, full} register;
  - ports write, read, clear;
  - same clock edge and reset as the stage.

## Test plan
- **Reset release, zero-wait memory returning PC as data:** F delivers PC 0,4,8 with F_valid pulses every 2 cycles; first valid F 2 cycles after release.
- **D_stall held 5 cycles while a response lands:** F holds its instruction; the buffer captures PC+4; IM_req stays 0 in S_FULL. After release, F gets the buffered word the next cycle, then fetch resumes at PC+8.
- **D_redirect to 32'h0000_0040 while in S_WAIT (rvalid 3 cycles later):** F_valid drops next cycle; the stale response is discarded; next IM_addr=0x40; perf_flushed +1.
- **D_redirect with D_target=32'h0000_0083:** IM_addr=0x80.
- **D_redirect and D_stall together, F_valid=1 and buffer full:** both cleared; next IM_addr=D_target.
- **SYS_reset pulsed mid-S_WAIT with PC=0x100:** F_valid=0 and IM_req=0 immediately; after release IM_addr=RESET_PC; a late rvalid is ignored.
- **PC=32'hFFFF_FFFC fetched:** next IM_addr=0. With FETCH_PERF_EN, perf_fetched counts each delivered instruction exactly once.
